// File: rtl/sync_data_memory_if.sv
// rtl/sync_data_memory_if.sv - request/response bus between a requester and sync_data_memory
interface sync_data_memory_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        respValid;
    logic [31:0] readData;
    logic        misaligned;

    modport master (
        output reqValid, reqWrite, reqSize, reqUnsigned, address, writeData,
        input  reqReady, respValid, readData, misaligned
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqUnsigned, address, writeData,
        output reqReady, respValid, readData, misaligned
    );
endinterface

// File: rtl/sync_data_memory.sv
// rtl/sync_data_memory.sv - byte-addressed 32-bit data memory with clear-on-reset and fixed-latency responses
module sync_data_memory #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_data_memory_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   counter_q, counter_d;
    logic                   clr_en;
    logic                   ready;

    logic [31:0]            mem_q [DEPTH];

    logic                   accept;
    logic                   store_en;
    logic                   mis;
    logic [ADDR_BITS-1:0]   idx;
    logic [3:0]             be;
    logic [31:0]            wlanes;
    logic [31:0]            rd_word;
    logic [31:0]            rd_shift;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [31:0]            load_val;

    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] mis_q;
    logic [31:0]             data_q [READ_LATENCY];

    // State register: reset forces INIT and restarts the clear sweep at word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Next state: sweep every word once, leave INIT after the last one
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        if (state_q == ST_INIT) begin
            counter_d = counter_q + 1'b1;
            if (counter_q == '1) begin
                state_d = ST_READY;
            end
        end
    end

    // FSM outputs: clear while in INIT, accept requests only in READY
    always_comb begin
        clr_en = (state_q == ST_INIT);
        ready  = (state_q == ST_READY);
    end

    assign bus.reqReady = ready;

    // Request decode: word index, alignment, lane enables and lane-replicated store data
    always_comb begin
        accept   = bus.reqValid && ready;
        idx      = bus.address[ADDR_BITS+1:2];
        mis      = 1'b0;
        be       = 4'b0000;
        wlanes   = bus.writeData;
        case (bus.reqSize)
            2'b00: begin
                be[bus.address[1:0]] = 1'b1;
                wlanes = {4{bus.writeData[7:0]}};
            end
            2'b01: begin
                mis = bus.address[0];
                be  = bus.address[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{bus.writeData[15:0]}};
            end
            default: begin
                mis = (bus.address[1:0] != 2'b00);
                be  = 4'b1111;
            end
        endcase
        store_en = accept && bus.reqWrite && !mis;
    end

    // Load extraction reads the array as it stands at the accept edge, so a
    // store accepted one cycle earlier is already visible
    always_comb begin
        rd_word  = mem_q[idx];
        rd_shift = rd_word >> {bus.address[1:0], 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = bus.address[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.reqSize)
            2'b00:   load_val = bus.reqUnsigned ? {24'h0, rd_byte}
                                                : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = bus.reqUnsigned ? {16'h0, rd_half}
                                                : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Memory array: cleared word by word during INIT, lane-masked stores in READY
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[counter_q] <= '0;
        end else if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline: one stage per cycle of latency; data is zero unless an aligned load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            mis_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= accept;
            mis_q[0]  <= accept && mis;
            data_q[0] <= (accept && !bus.reqWrite && !mis) ? load_val : 32'h0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                mis_q[i]  <= mis_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign bus.respValid  = vld_q[READ_LATENCY-1];
    assign bus.misaligned = mis_q[READ_LATENCY-1];
    assign bus.readData   = data_q[READ_LATENCY-1];
endmodule

// File: tb/tb_sync_data_memory.sv
// tb/tb_sync_data_memory.sv - directed vector bench for sync_data_memory
module tb_sync_data_memory;
    localparam int AB  = 4;
    localparam int LAT = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sync_data_memory_if bus ();

    sync_data_memory #(.ADDR_BITS(AB), .READ_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.reqValid    = 1'b1;
        bus.reqWrite    = wr;
        bus.reqSize     = size;
        bus.reqUnsigned = uns;
        bus.address     = addr;
        bus.writeData   = wdata;
    endtask

    task automatic idle_req();
        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqSize   = 2'b10;
        bus.reqUnsigned = 1'b0;
        bus.address   = 32'h0;
        bus.writeData = 32'h0;
    endtask

    // Issue one request at a negedge, then measure latency and check the response.
    task automatic run_vec(input vec_t v);
        int n;
        drive_req(v.wr, v.size, v.uns, v.addr, v.wdata);
        chk({v.name, "_ready"}, {31'b0, bus.reqReady}, 32'd1);
        @(posedge clk);
        #1 idle_req();
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.respValid) break;
        end
        chk({v.name, "_latency"}, n, LAT);
        chk({v.name, "_data"}, bus.readData, v.exp_data);
        chk({v.name, "_mis"}, {31'b0, bus.misaligned}, {31'b0, v.exp_mis});
        @(negedge clk);
        chk({v.name, "_pulse"}, {31'b0, bus.respValid}, 32'd0);
    endtask

    // Count rising edges until reqReady appears; respValid must stay low throughout.
    task automatic wait_init(input string name);
        int  n;
        logic saw_resp;
        n = 0;
        saw_resp = 1'b0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.respValid) saw_resp = 1'b1;
            if (bus.reqReady) break;
        end
        chk({name, "_init_cycles"}, n, 1 << AB);
        chk({name, "_no_resp"}, {31'b0, saw_resp}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{"lw_zero",     1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h00000000, 1'b0};
        vecs[1]  = '{"sw_10",       1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h00000000, 1'b0};
        vecs[2]  = '{"lb_10",       1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'h00000001, 1'b0};
        vecs[3]  = '{"lb_12",       1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{"lbu_12",      1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h000000FF, 1'b0};
        vecs[5]  = '{"lh_12",       1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0};
        vecs[6]  = '{"lhu_12",      1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h000080FF, 1'b0};
        vecs[7]  = '{"sb_11",       1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AB, 32'h00000000, 1'b0};
        vecs[8]  = '{"lw_10_sb",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80FFAB01, 1'b0};
        vecs[9]  = '{"sh_13_mis",   1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[10] = '{"lw_12_mis",   1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{"lw_10_same",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80FFAB01, 1'b0};
        vecs[12] = '{"lw_50_alias", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0,        32'h80FFAB01, 1'b0};
        vecs[13] = '{"lh_10",       1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFAB01, 1'b0};
        vecs[14] = '{"lbu_13",      1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0};
        vecs[15] = '{"lb_13",       1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[16] = '{"lw_sz11",     1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h80FFAB01, 1'b0};
        vecs[17] = '{"lb_11",       1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAB, 1'b0};
        vecs[18] = '{"sh_16",       1'b1, 2'b01, 1'b0, 32'h16, 32'h1234BEEF, 32'h00000000, 1'b0};
        vecs[19] = '{"lw_14",       1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'hBEEF0000, 1'b0};

        idle_req();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.reqReady}, 32'd0);
        chk("rst_resp",  {31'b0, bus.respValid}, 32'd0);
        chk("rst_data",  bus.readData, 32'h0);
        chk("rst_mis",   {31'b0, bus.misaligned}, 32'd0);
        rst_n = 1'b1;
        wait_init("first");

        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i]);
        end

        // Store then load of the same word on consecutive cycles
        drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        @(posedge clk);
        #1 drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(posedge clk);
        #1 idle_req();
        @(negedge clk);
        chk("b2b_early", {31'b0, bus.respValid}, 32'd0);
        @(negedge clk);
        chk("b2b_resp1_valid", {31'b0, bus.respValid}, 32'd1);
        chk("b2b_resp1_data",  bus.readData, 32'h0);
        @(negedge clk);
        chk("b2b_resp2_valid", {31'b0, bus.respValid}, 32'd1);
        chk("b2b_resp2_data",  bus.readData, 32'h12345678);
        @(negedge clk);
        chk("b2b_after", {31'b0, bus.respValid}, 32'd0);

        // Reset with two loads in flight
        drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(posedge clk);
        #1 drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1 idle_req();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_resp",  {31'b0, bus.respValid}, 32'd0);
        chk("midrst_ready", {31'b0, bus.reqReady}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_hold_resp", {31'b0, bus.respValid}, 32'd0);
        rst_n = 1'b1;
        wait_init("second");
        run_vec('{"lw_20_cleared", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0});
        run_vec('{"lw_10_cleared", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_data_memory.md
SYNC_DATA_MEMORY -- requirements
Module: sync_data_memory

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-index width; depth = 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 1, legal 1..4, cycles from request accept to response.
REQ-003 SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 reqValid  input  1  request present.
REQ-007 reqReady  output  1  block can accept a request.
REQ-008 reqWrite  input  1  1 = store, 0 = load.
REQ-009 reqSize  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-010 reqUnsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 address  input  32  byte address.
REQ-012 writeData  input  32  store data, right-aligned.
REQ-013 respValid  output  1  one-cycle response pulse.
REQ-014 readData  output  32  extended load result, valid with respValid.
REQ-015 misaligned  output  1  error flag, valid with respValid.

Function
REQ-016 Accept SHALL occur on rising edge when reqValid && reqReady; at most one request per cycle.
REQ-017 FSM SHALL have states INIT and READY; reset enters INIT with clear counter 0.
REQ-018 INIT SHALL write 0 to word[counter] each cycle, increment counter, reqReady=0; after word 2^ADDR_BITS-1, go to READY next cycle (INIT lasts exactly 2^ADDR_BITS cycles).
REQ-019 READY SHALL hold reqReady=1 continuously; fully pipelined, no back-pressure.
REQ-020 Word index SHALL be address[ADDR_BITS+1:2]; higher bits ignored (aliasing wrap).
REQ-021 Misaligned SHALL be: halfword with address[0]=1, or word with address[1:0]!=00; byte never misaligned.
REQ-022 Aligned store SHALL update only addressed lanes at the accept edge: byte lane address[1:0] <= writeData[7:0]; halfword lanes {address[1],1},{address[1],0} <= writeData[15:0]; word all lanes; little-endian.
REQ-023 Misaligned store SHALL leave memory unchanged.
REQ-024 Aligned load SHALL select the byte/halfword/word at the address and sign- or zero-extend per reqUnsigned.
REQ-025 Every accepted request (load or store, aligned or not) SHALL yield exactly one respValid pulse READ_LATENCY cycles after accept, in order.
REQ-026 readData SHALL be 0 for stores, misaligned requests, and whenever respValid=0; misaligned=1 only with respValid for misaligned requests.
REQ-027 Load accepted the cycle after a store to the same word SHALL return post-store data (read-after-write, no stale data).
REQ-028 Back-to-back accepts SHALL give back-to-back respValid pulses, one per cycle.

Reset
REQ-029 rst_n low SHALL immediately force respValid=0, readData=0, misaligned=0, reqReady=0, clear all pipeline valid bits, state INIT, counter 0.
REQ-030 Reset mid-INIT or mid-traffic SHALL discard in-flight responses and restart full memory clear after release.
REQ-031 Memory contents SHALL be defined only after INIT completes (all zeros).

Verification
REQ-032 Release reset, ADDR_BITS=4 -> reqReady 0 for 16 cycles, then 1; load any address -> 0x00000000.
REQ-033 Store word 0x80FF7F01 at 0x10; loads at 0x10: lb -> 0x00000001, lb @0x12 -> 0xFFFFFFFF, lbu @0x12 -> 0x000000FF, lh @0x12 -> 0xFFFF80FF, lhu @0x12 -> 0x000080FF.
REQ-034 sb 0xAB @0x11 after REQ-033 data -> load word 0x10 returns 0x80FFAB01; only lane 1 changed.
REQ-035 sh @0x13 and lw @0x12 -> respValid with misaligned=1, readData=0; memory unchanged.
REQ-036 Store 0x12345678 @0x20 then lw @0x20 next cycle, READ_LATENCY=3 -> responses at accept+3 each, consecutive, second readData=0x12345678.
REQ-037 Assert rst_n low with two loads in flight -> no respValid after reset; reqReady returns only after full INIT.
